// File: rtl/calc1_port_scheduler.sv
// rtl/calc1_port_scheduler.sv - round-robin scheduler sharing one calc1 request port
// Arbitrates requesters, drives the two-cycle calc1 issue and returns resp/data to the winner.
module calc1_port_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                      c_clk,
  input  logic                      reset,
  input  logic [0:NUM_REQ-1]        req_valid,
  input  logic [0:4*NUM_REQ-1]      req_cmd,
  input  logic [0:DATA_W*NUM_REQ-1] req_op1,
  input  logic [0:DATA_W*NUM_REQ-1] req_op2,
  output logic [0:NUM_REQ-1]        grant,
  output logic [0:NUM_REQ-1]        done,
  output logic [0:1]                done_resp,
  output logic [0:DATA_W-1]         done_data,
  output logic                      done_timeout,
  output logic [0:3]                calc_cmd,
  output logic [0:DATA_W-1]         calc_data,
  input  logic [0:1]                calc_resp,
  input  logic [0:DATA_W-1]         calc_data_in,
  output logic                      busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE1, S_ISSUE2, S_WAIT, S_RESP} state_t;
  state_t state, state_n;

  logic [PTR_W-1:0]  ptr, ptr_next, win, win_r, hi_win, lo_win;
  logic              hi_found, lo_found, found;
  logic [3:0]        cmd_r;
  logic [DATA_W-1:0] op1_r, op2_r, data_r;
  logic [1:0]        resp_r;
  logic              tout_r, grant_r;
  logic [7:0]        cnt;
  logic              wait_expired;

  logic [3:0]        cmd_arr [NUM_REQ];
  logic [DATA_W-1:0] op1_arr [NUM_REQ];
  logic [DATA_W-1:0] op2_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_arr[i] = req_cmd[4*i +: 4];
      op1_arr[i] = req_op1[DATA_W*i +: DATA_W];
      op2_arr[i] = req_op2[DATA_W*i +: DATA_W];
    end
  end

  // Lowest valid at/after ptr wins; otherwise wrap to the lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_win   = PTR_W'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_win   = PTR_W'(i);
        end
      end
    end
    found    = lo_found;
    win      = hi_found ? hi_win : lo_win;
    ptr_next = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end

  assign wait_expired = (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      win_r   <= '0;
      cmd_r   <= '0;
      op1_r   <= '0;
      op2_r   <= '0;
      resp_r  <= '0;
      data_r  <= '0;
      tout_r  <= 1'b0;
      grant_r <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      grant_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_r <= 1'b1;
            win_r   <= win;
            ptr     <= ptr_next;
            cmd_r   <= cmd_arr[win];
            op1_r   <= op1_arr[win];
            op2_r   <= op2_arr[win];
            // Preloaded answer for a zero cmd; issued ops overwrite it in WAIT.
            resp_r  <= 2'b11;
            data_r  <= '0;
            tout_r  <= 1'b0;
          end
        end
        S_ISSUE2: cnt <= '0;
        S_WAIT: begin
          if (calc_resp != 2'b00) begin
            resp_r <= calc_resp;
            data_r <= calc_data_in;
          end else if (wait_expired) begin
            resp_r <= 2'b00;
            data_r <= '0;
            tout_r <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (found) state_n = (cmd_arr[win] == 4'd0) ? S_RESP : S_ISSUE1;
      S_ISSUE1: state_n = S_ISSUE2;
      S_ISSUE2: state_n = S_WAIT;
      S_WAIT:   if (calc_resp != 2'b00 || wait_expired) state_n = S_RESP;
      S_RESP:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    grant        = '0;
    done         = '0;
    done_resp    = '0;
    done_data    = '0;
    done_timeout = 1'b0;
    calc_cmd     = '0;
    calc_data    = '0;
    busy         = (state != S_IDLE);
    grant[win_r] = grant_r;
    case (state)
      S_ISSUE1: begin
        calc_cmd  = cmd_r;
        calc_data = op1_r;
      end
      S_ISSUE2: calc_data = op2_r;
      S_RESP: begin
        done[win_r]  = 1'b1;
        done_resp    = resp_r;
        done_data    = data_r;
        done_timeout = tout_r;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_calc1_port_scheduler.sv
// tb/tb_calc1_port_scheduler.sv - self-checking bench for calc1_port_scheduler
// Event-level round-robin/latency model plus a calc1 stub; directed literal checks per scenario.
module tb_calc1_port_scheduler;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TO = 15;

  logic             c_clk = 1'b0;
  logic             reset;
  logic [0:NR-1]    req_valid;
  logic [0:4*NR-1]  req_cmd;
  logic [0:DW*NR-1] req_op1, req_op2;
  logic [0:NR-1]    grant, done;
  logic [0:1]       done_resp;
  logic [0:DW-1]    done_data;
  logic             done_timeout;
  logic [0:3]       calc_cmd;
  logic [0:DW-1]    calc_data;
  logic [0:1]       calc_resp = '0;
  logic [0:DW-1]    calc_data_in = '0;
  logic             busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 c_clk = ~c_clk;

  calc1_port_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .c_clk(c_clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_op1(req_op1), .req_op2(req_op2), .grant(grant), .done(done),
    .done_resp(done_resp), .done_data(done_data), .done_timeout(done_timeout),
    .calc_cmd(calc_cmd), .calc_data(calc_data), .calc_resp(calc_resp),
    .calc_data_in(calc_data_in), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // calc1 arithmetic: returns {resp, data}
  function automatic logic [DW+1:0] calc_fn(input logic [3:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (c)
      4'd1:    return s[DW] ? {2'b10, {DW{1'b0}}} : {2'b01, s[DW-1:0]};
      4'd2:    return (a < b) ? {2'b10, {DW{1'b0}}} : {2'b01, a - b};
      4'd5:    return {2'b01, a << b[4:0]};
      4'd6:    return {2'b01, a >> b[4:0]};
      default: return {2'b11, {DW{1'b0}}};
    endcase
  endfunction

  // calc1 stub: answers stub_delay WAIT cycles after the op2 beat, or never when silent
  int          stub_delay = 0;
  bit          stub_silent = 1'b0;
  int          st_phase = 0;
  int          st_cd = 0;
  logic [3:0]  st_cmd = '0, seen_cmd = '0;
  logic [DW-1:0] st_a = '0, st_b = '0;

  always @(negedge c_clk) begin
    calc_resp = 2'b00;
    calc_data_in = '0;
    if (reset) st_phase = 0;
    else begin
      case (st_phase)
        0: if (calc_cmd != 4'd0) begin
             st_cmd = calc_cmd;
             seen_cmd = calc_cmd;
             st_a = calc_data;
             st_phase = 1;
           end
        1: begin
             st_b = calc_data;
             st_cd = stub_delay;
             st_phase = stub_silent ? 0 : 2;
           end
        default: begin
          if (st_cd == 0) begin
            {calc_resp, calc_data_in} = calc_fn(st_cmd, st_a, st_b);
            st_phase = 0;
          end else st_cd--;
        end
      endcase
    end
  end

  // Input snapshot at the arbitration edge
  logic [0:NR-1]    s_valid;
  logic [0:4*NR-1]  s_cmd;
  logic [0:DW*NR-1] s_op1, s_op2;
  bit               s_rst;

  always @(posedge c_clk) begin
    cyc++;
    s_valid = req_valid;
    s_cmd = req_cmd;
    s_op1 = req_op1;
    s_op2 = req_op2;
    s_rst = reset;
  end

  // Reference model: one op in flight, rotating priority, fixed protocol latencies
  int            m_ptr = 0;
  bit            m_idle = 1'b1;
  bit            m_pend = 1'b0;
  int            m_idx, m_gc, m_dc;
  logic [3:0]    m_cmd;
  logic [DW-1:0] m_a, m_b, m_data;
  logic [1:0]    m_resp;
  bit            m_tout;

  always @(negedge c_clk) begin
    logic [0:NR-1] eg, ed;
    logic [3:0]    ec;
    logic [DW-1:0] ecd, edd;
    logic [1:0]    er;
    bit            et, eb;
    int            w;
    eg = '0; ed = '0; ec = '0; ecd = '0; edd = '0; er = '0; et = 1'b0; eb = 1'b0;
    if (reset) begin
      m_pend = 1'b0;
      m_idle = 1'b1;
      m_ptr = 0;
    end else begin
      if (m_idle && !s_rst && (s_valid != '0)) begin
        w = -1;
        for (int k = 0; k < NR; k++)
          if (w < 0 && s_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        eg[w] = 1'b1;
        m_ptr = (w + 1) % NR;
        m_pend = 1'b1;
        m_idx = w;
        m_gc = cyc;
        m_cmd = s_cmd[4*w +: 4];
        m_a = s_op1[DW*w +: DW];
        m_b = s_op2[DW*w +: DW];
        m_tout = 1'b0;
        if (m_cmd == 4'd0) begin
          m_dc = cyc;
          m_resp = 2'b11;
          m_data = '0;
        end else if (stub_silent) begin
          m_dc = cyc + 2 + TO;
          m_resp = 2'b00;
          m_data = '0;
          m_tout = 1'b1;
        end else begin
          m_dc = cyc + 3 + stub_delay;
          {m_resp, m_data} = calc_fn(m_cmd, m_a, m_b);
        end
      end
      if (m_pend && m_cmd != 4'd0 && cyc == m_gc) begin
        ec = m_cmd;
        ecd = m_a;
      end
      if (m_pend && m_cmd != 4'd0 && cyc == m_gc + 1) ecd = m_b;
      eb = m_pend;
      if (m_pend && cyc == m_dc) begin
        ed[m_idx] = 1'b1;
        er = m_resp;
        edd = m_data;
        et = m_tout;
        m_pend = 1'b0;
      end
      m_idle = !eb;
    end
    chk("m_grant", grant, eg);
    chk("m_done", done, ed);
    chk("m_done_resp", done_resp, er);
    chk("m_done_data", done_data, edd);
    chk("m_done_timeout", done_timeout, et);
    chk("m_calc_cmd", calc_cmd, ec);
    chk("m_calc_data", calc_data, ecd);
    chk("m_busy", busy, eb);
  end

  // Directed stimulus
  int            g_q[$];
  int            dq_idx[$];
  logic [DW-1:0] dq_data[$];
  int            g_cyc, d_cyc, d_idx;
  logic [1:0]    d_resp;
  logic [DW-1:0] d_data;
  bit            d_tout;
  bit            saw_cmd;

  task automatic post(input int i, input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_cmd[4*i +: 4] = c;
    req_op1[DW*i +: DW] = a;
    req_op2[DW*i +: DW] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic drain(input int n, input int budget);
    int got;
    got = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      @(negedge c_clk);
      if (calc_cmd != 4'd0) saw_cmd = 1'b1;
      for (int i = 0; i < NR; i++)
        if (grant[i]) begin
          req_valid[i] = 1'b0;
          g_q.push_back(i);
          g_cyc = cyc;
        end
      for (int i = 0; i < NR; i++)
        if (done[i]) begin
          d_idx = i;
          d_resp = done_resp;
          d_data = done_data;
          d_tout = done_timeout;
          d_cyc = cyc;
          dq_idx.push_back(i);
          dq_data.push_back(done_data);
          got++;
        end
    end
    chk("drain_count", got, n);
  endtask

  task automatic clear_logs();
    g_q.delete();
    dq_idx.delete();
    dq_data.delete();
  endtask

  task automatic pulse_reset(input int n);
    @(negedge c_clk);
    #1 reset = 1'b1;
    repeat (n) @(negedge c_clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_cmd = '0;
    req_op1 = '0;
    req_op2 = '0;
    repeat (4) @(negedge c_clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_calc_cmd", calc_cmd, 0);
    #1 reset = 1'b0;

    // 1: single add
    post(0, 4'd1, 32'h1, 32'h1FF_FFFF);
    drain(1, 60);
    chk("t1_idx", d_idx, 0);
    chk("t1_resp", d_resp, 1);
    chk("t1_data", d_data, 32'h0200_0000);
    chk("t1_latency", d_cyc - g_cyc, 3);
    chk("t1_cmd_seen", seen_cmd, 1);
    chk("t1_op1_seen", st_a, 32'h1);
    chk("t1_op2_seen", st_b, 32'h1FF_FFFF);

    // 2: all four at once from pointer 0, then rotation and wrap
    pulse_reset(2);
    clear_logs();
    for (int i = 0; i < NR; i++) post(i, 4'd1, 32'(i), 32'(i));
    drain(4, 200);
    chk("t2_grant0", g_q[0], 0);
    chk("t2_grant1", g_q[1], 1);
    chk("t2_grant2", g_q[2], 2);
    chk("t2_grant3", g_q[3], 3);
    chk("t2_data0", dq_data[0], 0);
    chk("t2_data1", dq_data[1], 2);
    chk("t2_data2", dq_data[2], 4);
    chk("t2_data3", dq_data[3], 6);
    clear_logs();
    post(1, 4'd1, 32'd7, 32'd8);
    drain(1, 60);
    chk("t2_next_grant", g_q[0], 1);
    chk("t2_next_data", d_data, 15);
    clear_logs();
    post(0, 4'd2, 32'd9, 32'd4);
    post(3, 4'd6, 32'h80, 32'd3);
    drain(2, 100);
    chk("t2_wrap_first", g_q[0], 3);
    chk("t2_wrap_second", g_q[1], 0);
    chk("t2_wrap_data_shr", dq_data[0], 32'h10);
    chk("t2_wrap_data_sub", dq_data[1], 5);

    // 3: error responses with a slower calc1
    stub_delay = 2;
    post(2, 4'd2, 32'd1, 32'd15);
    drain(1, 60);
    chk("t3_sub_idx", d_idx, 2);
    chk("t3_sub_resp", d_resp, 2);
    chk("t3_sub_latency", d_cyc - g_cyc, 5);
    post(3, 4'd1, 32'hFFFF_FFFF, 32'h1);
    drain(1, 60);
    chk("t3_add_idx", d_idx, 3);
    chk("t3_add_resp", d_resp, 2);
    stub_delay = 0;

    // 4: zero cmd never reaches calc1; invalid cmd is forwarded
    saw_cmd = 1'b0;
    seen_cmd = '0;
    post(1, 4'd0, 32'd5, 32'd6);
    drain(1, 60);
    chk("t4_zero_resp", d_resp, 3);
    chk("t4_zero_data", d_data, 0);
    chk("t4_zero_no_issue", saw_cmd, 0);
    chk("t4_zero_latency", d_cyc - g_cyc, 0);
    post(1, 4'd4, 32'd3, 32'd3);
    drain(1, 60);
    chk("t4_inv_resp", d_resp, 3);
    chk("t4_inv_forwarded", seen_cmd, 4);

    // 5: calc1 never answers
    stub_silent = 1'b1;
    post(0, 4'd1, 32'd3, 32'd4);
    drain(1, 80);
    chk("t5_timeout", d_tout, 1);
    chk("t5_resp", d_resp, 0);
    chk("t5_data", d_data, 0);
    chk("t5_latency", d_cyc - g_cyc, 2 + TO);

    // 6: reset during WAIT, then a clean shift
    clear_logs();
    post(0, 4'd1, 32'd9, 32'd9);
    begin
      int k;
      k = 0;
      while (grant == '0 && k < 40) begin
        @(negedge c_clk);
        k++;
      end
      chk("t6_grant_seen", grant, 4'b1000);
      req_valid[0] = 1'b0;
    end
    repeat (3) @(negedge c_clk);
    chk("t6_in_wait_busy", busy, 1);
    #1 reset = 1'b1;
    @(negedge c_clk);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_calc_data", calc_data, 0);
    @(negedge c_clk);
    #1 reset = 1'b0;
    stub_silent = 1'b0;
    dq_idx.delete();
    post(0, 4'd5, 32'h10, 32'd1);
    drain(1, 60);
    chk("t6_only_one_done", dq_idx.size(), 1);
    chk("t6_shl_resp", d_resp, 1);
    chk("t6_shl_data", d_data, 32'h20);

    repeat (3) @(negedge c_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
